// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and shared-ALU signals for alu_arbiter
// slave: the arbiter side; master: the requesters plus the external ALU.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_opA;
  logic [31:0] req0_opB;
  logic [3:0]  req0_sel;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_opA;
  logic [31:0] req1_opB;
  logic [3:0]  req1_sel;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp_data;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [3:0]  alu_sel;
  logic [31:0] alu_result;
  logic        busy;

  modport slave (
    input  req0_valid, req0_opA, req0_opB, req0_sel, rsp0_ready,
    input  req1_valid, req1_opA, req1_opB, req1_sel, rsp1_ready,
    input  alu_result,
    output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    output rsp_data, alu_operandA, alu_operandB, alu_sel, busy
  );

  modport master (
    output req0_valid, req0_opA, req0_opB, req0_sel, rsp0_ready,
    output req1_valid, req1_opA, req1_opB, req1_sel, rsp1_ready,
    output alu_result,
    input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
    input  rsp_data, alu_operandA, alu_operandB, alu_sel, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared combinational ALU
// ALU_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority to requester 0.
module alu_arbiter (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] res_q, res_d;
  logic        gnt_q, gnt_d;
  logic        pick;
  logic        any_valid;
  logic        rsp_taken;

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    if (bus.req0_valid && bus.req1_valid) pick = ~last_q;
    else                                  pick = ~bus.req0_valid;
  end
`else
  always_comb pick = ~bus.req0_valid;
`endif

  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign rsp_taken = gnt_q ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.req0_ready   = (state_q == ST_IDLE) & bus.req0_valid & ~pick;
  assign bus.req1_ready   = (state_q == ST_IDLE) & bus.req1_valid & pick;
  assign bus.rsp0_valid   = (state_q == ST_RESP) & ~gnt_q;
  assign bus.rsp1_valid   = (state_q == ST_RESP) & gnt_q;
  assign bus.rsp_data     = res_q;
  assign bus.alu_operandA = opa_q;
  assign bus.alu_operandB = opb_q;
  assign bus.alu_sel      = sel_q;
  assign bus.busy         = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sel_d   = sel_q;
    res_d   = res_q;
    gnt_d   = gnt_q;
`ifdef ALU_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          gnt_d   = pick;
          opa_d   = pick ? bus.req1_opA : bus.req0_opA;
          opb_d   = pick ? bus.req1_opB : bus.req0_opB;
          sel_d   = pick ? bus.req1_sel : bus.req0_sel;
          state_d = ST_EXEC;
`ifdef ALU_ARB_RR_EN
          last_d  = pick;
`endif
        end
      end
      ST_EXEC: begin
        res_d   = bus.alu_result;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_taken) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef ALU_ARB_RR_EN
  // Pointer starts at 1 so the first simultaneous request goes to requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter (honours ALU_ARB_RR_EN)
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [3:0] s);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      default: return a;
    endcase
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_operandA, bus.alu_operandB, bus.alu_sel);

  int          tests = 0;
  int          fails = 0;
  int          age;
  logic        exp_gnt;
  logic        last_ptr;
  logic [31:0] exp_res, exp_a, exp_b;
  logic [3:0]  exp_s;
  logic [31:0] seen_data;
  int          grants[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic arb_choice(logic v0, logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      return !last_ptr;
`else
      return 1'b0;
`endif
    end
    return v1 && !v0;
  endfunction

  task automatic model_reset();
    age = 0; exp_gnt = 0; last_ptr = 1; exp_res = 0;
    exp_a = 0; exp_b = 0; exp_s = 0;
  endtask

  // Reset asserted asynchronously away from a clock edge.
  task automatic do_reset();
    bus.req0_valid = 0; bus.req1_valid = 0;
    rst = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_alu_a", bus.alu_operandA, 0);
    chk("rst_alu_b", bus.alu_operandB, 0);
    chk("rst_alu_sel", bus.alu_sel, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock cycle: inputs already driven; check at negedge, advance model at posedge.
  task automatic cycle();
    logic g, acc, done;
    logic [31:0] a, b;
    logic [3:0]  s;
    @(negedge clk);
    g = arb_choice(bus.req0_valid, bus.req1_valid);
    chk("req0_ready", bus.req0_ready, (age == 0) && bus.req0_valid && !g);
    chk("req1_ready", bus.req1_ready, (age == 0) && bus.req1_valid && g);
    chk("busy", bus.busy, age != 0);
    chk("rsp0_valid", bus.rsp0_valid, (age >= 2) && !exp_gnt);
    chk("rsp1_valid", bus.rsp1_valid, (age >= 2) && exp_gnt);
    if (age >= 2) chk("rsp_data", bus.rsp_data, exp_res);
    chk("alu_operandA", bus.alu_operandA, exp_a);
    chk("alu_operandB", bus.alu_operandB, exp_b);
    chk("alu_sel", bus.alu_sel, exp_s);
    if (bus.req0_ready) grants.push_back(0);
    else if (bus.req1_ready) grants.push_back(1);
    if (bus.rsp0_valid || bus.rsp1_valid) seen_data = bus.rsp_data;
    acc  = (age == 0) && (bus.req0_valid || bus.req1_valid);
    done = (age >= 2) && (exp_gnt ? bus.rsp1_ready : bus.rsp0_ready);
    a = g ? bus.req1_opA : bus.req0_opA;
    b = g ? bus.req1_opB : bus.req0_opB;
    s = g ? bus.req1_sel : bus.req0_sel;
    @(posedge clk);
    if (acc) begin
      exp_gnt = g; last_ptr = g; age = 1;
      exp_a = a; exp_b = b; exp_s = s; exp_res = alu_fn(a, b, s);
    end else if (done) begin
      age = 0;
    end else if (age != 0) begin
      age = (age < 2) ? age + 1 : 2;
    end
    #1;
  endtask

  task automatic set_req(int n, logic v, logic [31:0] a, logic [31:0] b, logic [3:0] s);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_opA = a; bus.req0_opB = b; bus.req0_sel = s;
    end else begin
      bus.req1_valid = v; bus.req1_opA = a; bus.req1_opB = b; bus.req1_sel = s;
    end
  endtask

  initial begin
    int exp_order[4];
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    do_reset();

    // Basic ADD, with opA altered after acceptance.
    set_req(0, 1, 5, 3, 4'd0);
    bus.rsp0_ready = 1;
    cycle();
    set_req(0, 0, 100, 3, 4'd0);
    seen_data = 0;
    cycle();
    cycle();
    chk("add_5_3_result", seen_data, 8);
    cycle();

    // Both requesters held valid: grant order.
    grants.delete();
    set_req(0, 1, 32'd20, 32'd4, 4'd1);
    set_req(1, 1, 32'd7, 32'd9, 4'd0);
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    repeat (12) cycle();
    set_req(0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0);
`ifdef ALU_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    chk("grant_count", grants.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) chk($sformatf("grant_order[%0d]", i), grants[i], exp_order[i]);
    repeat (3) cycle();

    // Response back-pressure on requester 1.
    bus.rsp1_ready = 0;
    set_req(1, 1, 32'hdead0000, 32'h0000beef, 4'd3);
    cycle();
    set_req(1, 0, 0, 0, 0);
    cycle();
    repeat (5) cycle();
    bus.rsp1_ready = 1;
    cycle();
    chk("hold_result", seen_data, 32'hdeadbeef);
    cycle();

    // Requester 1 arrives while requester 0 is in flight.
    set_req(0, 1, 32'd40, 32'd2, 4'd0);
    bus.rsp0_ready = 1;
    cycle();
    set_req(0, 0, 0, 0, 0);
    set_req(1, 1, 32'd10, 32'd3, 4'd1);
    cycle();
    cycle();
    chk("inflight_first", seen_data, 42);
    cycle();
    set_req(1, 0, 0, 0, 0);
    cycle();
    cycle();
    chk("sub_10_3", seen_data, 7);
    cycle();

    // Reset while in EXEC abandons the operation.
    set_req(0, 1, 32'd1, 32'd1, 4'd0);
    cycle();
    set_req(0, 0, 0, 0, 0);
    do_reset();
    repeat (3) cycle();
    set_req(1, 1, 32'hf0, 32'h0f, 4'd4);
    cycle();
    set_req(1, 0, 0, 0, 0);
    cycle();
    cycle();
    chk("after_reset_xor", seen_data, 32'hff);
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      set_req(0, ($urandom_range(0, 2) != 0), $urandom, $urandom, 4'($urandom_range(0, 7)));
      set_req(1, ($urandom_range(0, 2) != 0), $urandom, $urandom, 4'($urandom_range(0, 7)));
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (i == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have these ports (name direction width meaning), clock and reset first:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle
req0_opA  input  32  requester 0 operand A
req0_opB  input  32  requester 0 operand B
req0_sel  input  4  requester 0 ALU select code
rsp0_valid  output  1  result for requester 0 available
rsp0_ready  input  1  requester 0 consumes result
req1_valid, req1_ready, req1_opA, req1_opB, req1_sel, rsp1_valid, rsp1_ready  same as requester 0, for requester 1
rsp_data  output  32  result of the granted operation, shared by both responders
alu_operandA  output  32  operand A driven to the shared ALU
alu_operandB  output  32  operand B driven to the shared ALU
alu_sel  output  4  select code driven to the shared ALU
alu_result  input  32  combinational result from the shared ALU
busy  output  1  high whenever state is not IDLE
REQ-002 Clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-004 IDLE: if any reqN_valid is high, the block SHALL grant exactly one requester, assert that reqN_ready combinationally in the same cycle, latch its opA/opB/sel and grant index, and move to EXEC; with no valid request it SHALL remain in IDLE.
REQ-005 reqN_ready SHALL be high only in IDLE for the granted requester; never in EXEC or RESP.
REQ-006 EXEC: the block SHALL drive latched operands/sel onto alu_operandA/B/alu_sel, register alu_result into the result register at the clock edge, and move to RESP.
REQ-007 RESP: rspN_valid SHALL be high only for the latched grant index; rsp_data SHALL hold the registered result, stable until handshake.
REQ-008 RESP: when rspN_ready of the granted requester is high, the block SHALL return to IDLE; otherwise it SHALL hold RESP and all outputs stable.
REQ-009 Latency: request accepted at edge N, rspN_valid SHALL first be high in cycle N+2; minimum issue interval 3 cycles.
REQ-010 alu_operandA/B/alu_sel SHALL always reflect the latched operand registers (including in IDLE and RESP).
REQ-011 Requester inputs changing after acceptance SHALL NOT affect the in-flight result.
REQ-012 rsp_data width is 32 bits; no truncation or extension of alu_result.
REQ-013 Requests arriving while busy SHALL be held off (ready low) and considered at the next IDLE cycle.

Reset
REQ-014 Asserting rst SHALL immediately force: state IDLE, operand registers 0, sel 0, result register 0, grant index 0, last-grant pointer 1.
REQ-015 During and right after reset all ready/valid outputs SHALL be 0 except reqN_ready as defined by REQ-004; busy SHALL be 0.
REQ-016 Reset mid-operation (EXEC or RESP) SHALL abandon the operation; no rspN_valid SHALL be produced for it.

Configuration
REQ-017 Macro ALU_ARB_RR_EN defined: round-robin; when both valid in IDLE, grant the requester other than the last-grant pointer; pointer updates to the granted index on acceptance.
REQ-018 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins simultaneous requests; pointer register SHALL not be present.
REQ-019 A single requester valid SHALL be granted in either configuration.

Verification
REQ-020 After reset, req0 valid opA=5 opB=3 sel=ADD -> req0_ready same cycle, rsp0_valid 2 cycles later, rsp_data=8.
REQ-021 RR_EN: both valid continuously for 4 ops -> grant order 0,1,0,1; without RR_EN -> 0,0,0,0.
REQ-022 RESP with rsp1_ready held low 5 cycles, then high -> rsp1_valid and rsp_data stable all 5 cycles, IDLE next cycle.
REQ-023 Change req0_opA from 5 to 100 after acceptance -> rsp_data still reflects 5.
REQ-024 Assert rst during EXEC -> busy=0 immediately, no rspN_valid, next request serviced normally.
REQ-025 req1 valid while req0 in flight -> req1_ready low until IDLE, then accepted; result correct, e.g. SUB 10-3=7.
